codec_adc_serial_source: RTL
============================

Name: codec_adc_serial_source

Overview:
- Transmitter end of the codec ADC serial audio link: generates bclk and ADC lrclk from the system clock.
- Shifts 16-bit left/right samples out MSB-first, left-justified, on one data wire.
- Data changes on the falling edge of bclk, matching what serial_to_parallel captures.
- Used as a codec stand-in on boards without a WM8731, and as a bench stimulus source for the serial_to_parallel → dsp_subsystem → parallel_to_serial path.

Parameters:
- CLK_DIV, 2: clock cycles per bclk half-period (bclk = clock / (2*CLK_DIV)); legal range ≥1.
- SLOT_BITS, 32: bclk periods per channel slot; lrclk period = 2*SLOT_BITS bclk; legal range ≥ SAMPLE_WIDTH.
- SAMPLE_WIDTH, 16: bits per channel sample.

Ports:
- clock, input, 1: system clock; all state on its rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- left_sample, input, SAMPLE_WIDTH: left channel sample, two's complement.
- right_sample, input, SAMPLE_WIDTH: right channel sample.
- sample_valid, input, 1: left/right pair offered.
- sample_ready, output, 1: staging register empty; the pair is accepted when valid & ready.
- bclk, output, 1: generated bit clock (registered).
- lrclk, output, 1: frame clock; 1 = left slot, 0 = right slot (registered).
- adcdat, output, 1: serial data (registered).
- underrun, output, 1: sticky; set when a frame starts with no staged pair; cleared only by reset.
- frame_start, output, 1: one-cycle pulse on the clock cycle a frame is loaded.

Behaviour:
- Reset values: bclk=0, lrclk=0, adcdat=0, sample_ready=1, underrun=0, frame_start=0. Divider=0. bit_cnt=2*SLOT_BITS-1. Staging register empty. Active frame (L,R)=(0,0).
- Divider:
  - div_cnt counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps and bclk toggles.
  - Falling-edge event (fe) = the cycle where div_cnt==CLK_DIV-1 and bclk==1; bclk goes 0 on the next edge.
  - First fe occurs 2*CLK_DIV cycles after reset release.
- On every fe, all registered together:
  - bit_cnt ← (bit_cnt==2*SLOT_BITS-1) ? 0 : bit_cnt+1.
  - With n = new bit_cnt: lrclk ← (n < SLOT_BITS).
  - p = n mod SLOT_BITS. adcdat ← frame channel bit [SAMPLE_WIDTH-1-p] if p < SAMPLE_WIDTH, else 0.
  - Left channel when n < SLOT_BITS, right otherwise.
  - MSB is coincident with the lrclk transition (left-justified, no one-bit delay).
- Frame load (fe with n==0):
  - If the staging register is full: copy it into the active frame and mark staging empty.
  - If staging is empty: the active frame is reused unchanged and underrun ← 1.
  - frame_start pulses on this cycle in both cases.
  - Bit 0 of the slot uses the newly loaded frame.
- Handshake:
  - sample_ready = staging empty, registered.
  - On valid & ready, both samples are captured into staging; ready drops next cycle.
  - Samples must hold only during the accepting cycle.
  - Valid while not ready is ignored; no data is lost from staging and nothing is overwritten.
  - A load and an acceptance cannot coincide: acceptance requires empty, load requires full.
  - If valid & ready occurs on a frame-load cycle: the load sees empty (underrun, reuse), and the new pair lands in staging for the next frame.
- Throughput: one pair per 2*SLOT_BITS*2*CLK_DIV clocks (256 clocks at defaults).
- Reset mid-frame: every output returns to its reset value immediately (asynchronous). Staged data is discarded. The next frame after release starts from bit_cnt wrap.
- Sign and width: samples are transmitted verbatim, with no extension; padding bits are 0.

Test Plan:
- Reset release, no samples → bclk period 4 clocks. First fe at clock 4 sets lrclk=1. frame_start pulses at clock 4 and every 256 clocks. adcdat stays 0. underrun=1 after the first frame_start.
- Offer L=16'hA5C3, R=16'h8001 before the first fe → sample_ready drops the cycle after acceptance. Left slot adcdat bits = 1010010111000011 then 16 zeros. Right slot (lrclk=0) = 1000000000000001 then zeros. underrun stays 0. sample_ready returns to 1 right after frame_start.
- Hold sample_valid=1 with new data every cycle → exactly one pair is accepted per frame. The pair transmitted in frame k+1 is the one accepted after frame k's load. No underrun.
- Supply a pair only once, then stop → that frame repeats identically on every following frame. underrun is set at the second frame_start and stays set.
- Assert reset_n=0 mid-left slot (bit 7 of 16'hFFFF) → bclk, lrclk and adcdat go 0 immediately, ready=1, underrun=0. After release, the first fe is a frame start with L=R=0.
- Loop back through serial_to_parallel (CLK_DIV=2, SLOT_BITS=32) with ramp L=0..99 → the parallel output sequence equals the ramp, delayed by one lrclk frame, with no dropped values.

Source files
------------

// File: rtl/codec_adc_serial_source.sv
// Codec ADC serial source: transmitter end of the serial audio link.
// Generates bclk and lrclk from the system clock and shifts a staged
// left/right sample pair out MSB-first, left-justified, one frame per
// lrclk period. Data changes on bclk falling edges.
module codec_adc_serial_source #(
  parameter int CLK_DIV      = 2,
  parameter int SLOT_BITS    = 32,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [SAMPLE_WIDTH-1:0] left_sample,
  input  logic [SAMPLE_WIDTH-1:0] right_sample,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    adcdat,
  output logic                    underrun,
  output logic                    frame_start
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_BITS);

  logic [DIV_W-1:0]        div_cnt;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    stage_empty;
  logic [SAMPLE_WIDTH-1:0] stage_l;
  logic [SAMPLE_WIDTH-1:0] stage_r;
  logic [SAMPLE_WIDTH-1:0] act_l;
  logic [SAMPLE_WIDTH-1:0] act_r;

  // Combinational next-bit decode
  logic                    fe;
  logic                    load;
  logic                    in_left;
  logic [CNT_W-1:0]        bit_next;
  logic [CNT_W-1:0]        slot_pos;
  logic [SAMPLE_WIDTH-1:0] frame_l_nxt;
  logic [SAMPLE_WIDTH-1:0] frame_r_nxt;
  logic [SAMPLE_WIDTH-1:0] chan;
  logic                    dat_nxt;

  assign sample_ready = stage_empty;

  // Bit-clock divider: toggle bclk every CLK_DIV system clocks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      // NOTE: state updates use non-blocking assignments so every flop
      // samples the pre-edge values, independent of block ordering.
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Decode the falling-edge event, the next bit position and its data bit.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would infer a latch.
    dat_nxt     = 1'b0;
    fe          = bclk && (div_cnt == DIV_LAST);
    bit_next    = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
    load        = fe && (bit_next == '0);
    in_left     = bit_next < SLOT_LEN;
    slot_pos    = in_left ? bit_next : bit_next - SLOT_LEN;
    // A frame load with a full staging register switches to the new pair
    // immediately, so bit 0 of the left slot already carries it.
    frame_l_nxt = (load && !stage_empty) ? stage_l : act_l;
    frame_r_nxt = (load && !stage_empty) ? stage_r : act_r;
    chan        = in_left ? frame_l_nxt : frame_r_nxt;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      if (slot_pos == CNT_W'(SAMPLE_WIDTH - 1 - i)) dat_nxt = chan[i];
    end
  end

  // Serializer: advance the bit counter and drive lrclk/adcdat on each fe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt     <= CNT_LAST;
      lrclk       <= 1'b0;
      adcdat      <= 1'b0;
      act_l       <= '0;
      act_r       <= '0;
      underrun    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= load;
      if (fe) begin
        bit_cnt <= bit_next;
        lrclk   <= in_left;
        adcdat  <= dat_nxt;
      end
      if (load) begin
        act_l <= frame_l_nxt;
        act_r <= frame_r_nxt;
        if (stage_empty) underrun <= 1'b1;
      end
    end
  end

  // Staging flag: set on acceptance, cleared when a frame load consumes it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_empty <= 1'b1;
    end else if (load && !stage_empty) begin
      stage_empty <= 1'b1;
    end else if (sample_valid && stage_empty) begin
      stage_empty <= 1'b0;
    end
  end

  // Staging data: captured on acceptance only.
  always_ff @(posedge clock) begin
    // NOTE: the data registers carry no reset; stage_empty alone decides
    // whether their contents are ever used.
    if (sample_valid && stage_empty) begin
      stage_l <= left_sample;
      stage_r <= right_sample;
    end
  end

endmodule
